// File: rtl/accumulate.sv
// accumulate: signed N-term dot-product reducer, valid/ready on both sides; define ACCUMULATE_SATURATE_EN to clamp results instead of wrapping.
// Latency: result valid the cycle after the Nth term is accepted, one term per clock; s_rdy drops only when the Nth term would overwrite an unconsumed result.
module accumulate #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_stb,
  input  logic [2*W-1:0] s_dat,
  output logic           s_rdy,
  input  logic           m_rdy,
  output logic           m_stb,
  output logic [2*W-1:0] m_dat
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int A  = 2*W + $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  logic [CW-1:0]         cnt;
  logic signed [A-1:0]   acc;
  logic signed [A-1:0]   sum;
  logic signed [A-1:0]   term;
  logic signed [2*W-1:0] s_term;
  logic [2*W-1:0]        fin;
  logic                  accept;

  assign s_term = s_dat;
  assign s_rdy  = (cnt != LAST) | ~m_stb | m_rdy;
  assign accept = s_stb & s_rdy;

  // First term of a batch ignores the stale acc, so no clear cycle is needed.
  always_comb begin
    term = s_term;
    sum  = ((cnt == '0) ? '0 : acc) + term;
  end

`ifdef ACCUMULATE_SATURATE_EN
  localparam logic signed [A-1:0] SMAX = $signed((A'(1) << (2*W-1)) - A'(1));
  localparam logic signed [A-1:0] SMIN = $signed(~((A'(1) << (2*W-1)) - A'(1)));

  always_comb begin
    if (sum > SMAX)      fin = SMAX[2*W-1:0];
    else if (sum < SMIN) fin = SMIN[2*W-1:0];
    else                 fin = sum[2*W-1:0];
  end
`else
  assign fin = sum[2*W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      m_stb <= 1'b0;
      m_dat <= '0;
    end else begin
      if (m_stb && m_rdy)
        m_stb <= 1'b0;
      // A completing batch overrides the drain above: back-to-back results, no bubble.
      if (accept) begin
        if (cnt == LAST) begin
          m_dat <= fin;
          m_stb <= 1'b1;
          cnt   <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_accumulate.sv
// Bench for accumulate: directed cases plus random traffic against a batch-sum reference model.
module tb_accumulate;
  localparam int W = 8;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_stb = 1'b0;
  logic [15:0] s_dat = '0;
  logic        s_rdy;
  logic        m_rdy = 1'b0;
  logic        m_stb;
  logic [15:0] m_dat;

  logic        s1_stb = 1'b0;
  logic [15:0] s1_dat = '0;
  logic        s1_rdy;
  logic        m1_rdy = 1'b0;
  logic        m1_stb;
  logic [15:0] m1_dat;

  always #5 clk = ~clk;

  accumulate #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .s_stb(s_stb), .s_dat(s_dat), .s_rdy(s_rdy),
    .m_rdy(m_rdy), .m_stb(m_stb), .m_dat(m_dat)
  );

  accumulate #(.W(W), .N(1)) dut1 (
    .clk(clk), .rst(rst), .s_stb(s1_stb), .s_dat(s1_dat), .s_rdy(s1_rdy),
    .m_rdy(m1_rdy), .m_stb(m1_stb), .m_dat(m1_dat)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: terms collected per batch, plus one pending output slot.
  longint      batch[$];
  logic        pend = 1'b0;
  logic [15:0] pend_val = '0;
  int          accepts = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] final_val(input longint s);
    logic [63:0] v;
    v = s;
`ifdef ACCUMULATE_SATURATE_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  // Entered at a negedge; drives one cycle of the N=4 DUT and checks it.
  task automatic tick(input logic stb, input logic [15:0] dat, input logic rdy);
    logic   exp_rdy;
    longint tot;
    s_stb = stb;
    s_dat = dat;
    m_rdy = rdy;
    #1;
    exp_rdy = !((batch.size() == N-1) && pend && !rdy);
    chk("s_rdy", {31'd0, s_rdy}, {31'd0, exp_rdy});
    @(posedge clk);
    if (pend && rdy) pend = 1'b0;
    if (stb && exp_rdy) begin
      accepts++;
      batch.push_back(longint'($signed(dat)));
      if (batch.size() == N) begin
        tot = 0;
        foreach (batch[i]) tot += batch[i];
        batch.delete();
        pend     = 1'b1;
        pend_val = final_val(tot);
      end
    end
    @(negedge clk);
    chk("m_stb", {31'd0, m_stb}, {31'd0, pend});
    if (pend) chk("m_dat", {16'd0, m_dat}, {16'd0, pend_val});
  endtask

  task automatic feed4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    tick(1'b1, a, 1'b1);
    tick(1'b1, b, 1'b1);
    tick(1'b1, c, 1'b1);
    tick(1'b1, d, 1'b1);
  endtask

  initial begin
    logic [15:0] corner [4];
    logic [15:0] v;
    int a0;
    corner[0] = 16'h7FFF; corner[1] = 16'h8000; corner[2] = 16'h4000; corner[3] = 16'hC000;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_m_stb", {31'd0, m_stb}, 32'd0);
    chk("rst_m_dat", {16'd0, m_dat}, 32'd0);
    chk("rst_s_rdy", {31'd0, s_rdy}, 32'd1);
    chk("rst_m1_stb", {31'd0, m1_stb}, 32'd0);
    chk("rst_m1_dat", {16'd0, m1_dat}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: 10+20+30+40
    tick(1'b1, 16'd10, 1'b1);
    tick(1'b1, 16'd20, 1'b1);
    tick(1'b1, 16'd30, 1'b1);
    chk("t1_no_early_stb", {31'd0, m_stb}, 32'd0);
    tick(1'b1, 16'd40, 1'b1);
    chk("t1_stb", {31'd0, m_stb}, 32'd1);
    chk("t1_dat", {16'd0, m_dat}, 32'd100);
    tick(1'b0, 16'd0, 1'b1);
    chk("t1_drain", {31'd0, m_stb}, 32'd0);

    // 2: -5,3,-1,2 -> -1
    feed4(16'hFFFB, 16'd3, 16'hFFFF, 16'd2);
    chk("t2_dat", {16'd0, m_dat}, 32'h0000FFFF);
    tick(1'b0, 16'd0, 1'b1);

    // 3: overflow handling
    feed4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
`ifdef ACCUMULATE_SATURATE_EN
    chk("t3_pos", {16'd0, m_dat}, 32'h00007FFF);
`else
    chk("t3_pos", {16'd0, m_dat}, 32'h00000000);
`endif
    tick(1'b0, 16'd0, 1'b1);
    feed4(16'hC000, 16'hC000, 16'hC000, 16'hC000);
`ifdef ACCUMULATE_SATURATE_EN
    chk("t3_neg", {16'd0, m_dat}, 32'h00008000);
`else
    chk("t3_neg", {16'd0, m_dat}, 32'h00000000);
`endif
    tick(1'b0, 16'd0, 1'b1);

    // 4: backpressure, 8 back-to-back ones with m_rdy low
    a0 = accepts;
    for (int i = 0; i < 8; i++) tick(1'b1, 16'd1, 1'b0);
    tick(1'b1, 16'd1, 1'b0);
    chk("t4_accepts", accepts - a0, 32'd7);
    chk("t4_held_stb", {31'd0, m_stb}, 32'd1);
    chk("t4_held_dat", {16'd0, m_dat}, 32'd4);
    tick(1'b1, 16'd1, 1'b1);
    chk("t4_accepts_after", accepts - a0, 32'd8);
    chk("t4_next_stb", {31'd0, m_stb}, 32'd1);
    chk("t4_next_dat", {16'd0, m_dat}, 32'd4);
    tick(1'b0, 16'd0, 1'b1);

    // 5: async reset with a pending result and a partial batch
    for (int i = 0; i < 4; i++) tick(1'b1, 16'd7, 1'b0);
    tick(1'b1, 16'd9, 1'b0);
    tick(1'b1, 16'd9, 1'b0);
    s_stb = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_async_stb", {31'd0, m_stb}, 32'd0);
    chk("t5_async_rdy", {31'd0, s_rdy}, 32'd1);
    batch.delete();
    pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    feed4(16'd1, 16'd1, 16'd1, 16'd1);
    chk("t5_dat", {16'd0, m_dat}, 32'd4);
    tick(1'b0, 16'd0, 1'b1);

    // 6: N=1 pass-through
    for (int i = 1; i <= 3; i++) begin
      s1_stb = 1'b1;
      s1_dat = 16'(i);
      m1_rdy = 1'b1;
      #1;
      chk("t6_rdy", {31'd0, s1_rdy}, 32'd1);
      @(negedge clk);
      chk("t6_stb", {31'd0, m1_stb}, 32'd1);
      chk("t6_dat", {16'd0, m1_dat}, i);
    end
    s1_stb = 1'b0;
    @(negedge clk);
    chk("t6_drain", {31'd0, m1_stb}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      tick($urandom_range(0, 9) < 7, v, $urandom_range(0, 9) < 6);
    end
    tick(1'b0, 16'd0, 1'b1);
    tick(1'b0, 16'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
